// File: rtl/johnson_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : johnson_cnt_ctrl
// Description : Parametrised Johnson (twisted-ring) counter. It steps forward
//               or in reverse under enable, and it has a synchronous clear and
//               a synchronous load. It detects illegal ring states and illegal
//               load values, and it can optionally correct them. It also
//               produces a registered phase index and a one-cycle wrap pulse.
//               The counter walks a glitch-free sequence of 2*WIDTH states.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH        ring length in flops (2..32)
//   SELF_CORRECT 1 = illegal states/loads are forced to all-zeros
//                0 = no correction (the illegal flag is still raised)
//   PW           phase index width, derived, do not override
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   step enable
//   dir_up     in   1 = forward step, 0 = reverse step
//   clr        in   synchronous clear (highest priority)
//   load       in   synchronous load of load_val
//   load_val   in   [WIDTH]  value to load
//   o_cnt      out  [WIDTH]  registered ring state
//   o_phase    out  [PW]     registered phase index of o_cnt
//   o_wrap     out  one-cycle pulse on a sequence wrap
//   o_illegal  out  one-cycle pulse on an illegal state/load
// ============================================================================
module johnson_cnt_ctrl #(
    parameter int WIDTH        = 4,
    parameter int SELF_CORRECT = 1,
    parameter int PW           = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir_up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic [PW-1:0]    o_phase,
    output logic             o_wrap,
    output logic             o_illegal
);

    localparam logic [PW:0]      c_NSTATES = (PW + 1)'(2 * WIDTH);
    // The ring state 0..01 is the last phase (2*WIDTH-1) of the forward sequence.
    localparam logic [WIDTH-1:0] c_LAST    = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [PW-1:0]    r_phase;
    logic             r_wrap;
    logic             r_illegal;

    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_fix_load;
    logic [WIDTH-1:0] w_fix_step;
    logic             w_cur_legal;
    logic             w_load_legal;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [PW-1:0]    w_phase_nxt;
    logic             w_wrap_nxt;
    logic             w_illegal_nxt;

    // A legal Johnson word has at most one boundary between adjacent bits
    // (1..10..0 or 0..01..1). So the adjacent-bit difference vector must have
    // zero or one bits set.
    function automatic logic is_legal(input logic [WIDTH-1:0] s);
        logic [WIDTH-2:0] diff;
        diff     = s[WIDTH-1:1] ^ s[WIDTH-2:0];
        is_legal = ((diff & (diff - (WIDTH - 1)'(1))) == '0);
    endfunction

    // The phase comes from the popcount. Words that lead with ones (and the
    // all-zeros word) are in the first half of the sequence. Words that lead
    // with zeros are in the second half. For illegal words the result is just
    // the same deterministic arithmetic.
    function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] s);
        logic [PW:0] pop;
        logic [PW:0] ph;
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + (PW + 1)'(s[i]);
        end
        if (s[WIDTH-1] || (s == '0)) begin
            ph = pop;
        end else begin
            ph = c_NSTATES - pop;
        end
        phase_of = ph[PW-1:0];
    endfunction

    assign w_fwd        = {~r_cnt[0], r_cnt[WIDTH-1:1]};
    assign w_rev        = {r_cnt[WIDTH-2:0], ~r_cnt[WIDTH-1]};
    assign w_step       = dir_up ? w_fwd : w_rev;
    assign w_cur_legal  = is_legal(r_cnt);
    assign w_load_legal = is_legal(load_val);

    // These are the targets used when an illegal state or load is seen. With
    // correction, both go to the all-zeros home state. Without correction, the
    // normal action proceeds unchanged.
    generate
        if (SELF_CORRECT != 0) begin : g_correct
            assign w_fix_load = '0;
            assign w_fix_step = '0;
        end else begin : g_no_correct
            assign w_fix_load = load_val;
            assign w_fix_step = w_step;
        end
    endgenerate

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_wrap_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (load) begin
            if (w_load_legal) begin
                w_cnt_nxt = load_val;
            end else begin
                w_cnt_nxt     = w_fix_load;
                w_illegal_nxt = 1'b1;
            end
        end else if (en) begin
            if (w_cur_legal) begin
                w_cnt_nxt  = w_step;
                // A forward wrap leaves 0..01 and a reverse wrap leaves 0..0.
                w_wrap_nxt = dir_up ? (r_cnt == c_LAST) : (r_cnt == '0);
            end else begin
                w_cnt_nxt     = w_fix_step;
                w_illegal_nxt = 1'b1;
            end
        end
    end

    assign w_phase_nxt = phase_of(w_cnt_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_phase   <= '0;
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_phase   <= w_phase_nxt;
            r_wrap    <= w_wrap_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_phase   = r_phase;
    assign o_wrap    = r_wrap;
    assign o_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_johnson_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_cnt_ctrl
// Description : Self-checking bench for johnson_cnt_ctrl. It uses three
//               instances that share one set of controls: WIDTH=4 with
//               self-correction, WIDTH=4 without self-correction, and WIDTH=5
//               with self-correction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_cnt_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir_up;
    logic       clr;
    logic       load;
    logic [3:0] load_val4;
    logic [4:0] load_val5;

    logic [3:0] cnt4,  cnt4n;
    logic [2:0] ph4,   ph4n;
    logic       wr4,   wr4n, il4, il4n;
    logic [4:0] cnt5;
    logic [3:0] ph5;
    logic       wr5,   il5;

    int checks = 0;
    int errors = 0;

    // Reference model state: the raw ring value plus the expected pulses.
    int unsigned mv4, mv4n, mv5;
    bit          mw4, mw4n, mw5, mi4, mi4n, mi5;

    johnson_cnt_ctrl #(.WIDTH(4), .SELF_CORRECT(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir_up(dir_up), .clr(clr), .load(load),
        .load_val(load_val4), .o_cnt(cnt4), .o_phase(ph4), .o_wrap(wr4), .o_illegal(il4)
    );
    johnson_cnt_ctrl #(.WIDTH(4), .SELF_CORRECT(0)) u_dut4n (
        .clk(clk), .rst_n(rst_n), .en(en), .dir_up(dir_up), .clr(clr), .load(load),
        .load_val(load_val4), .o_cnt(cnt4n), .o_phase(ph4n), .o_wrap(wr4n), .o_illegal(il4n)
    );
    johnson_cnt_ctrl #(.WIDTH(5), .SELF_CORRECT(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir_up(dir_up), .clr(clr), .load(load),
        .load_val(load_val5), .o_cnt(cnt5), .o_phase(ph5), .o_wrap(wr5), .o_illegal(il5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic       en;
        logic       dir;
        logic [3:0] lv;
        logic [3:0] cnt;
        int         phase;
        logic       wrap;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(logic c, logic ld, logic e, logic d, logic [3:0] lv,
                                    logic [3:0] cnt, int phase, logic wrap, logic ill);
        vec_t v;
        v.clr = c; v.load = ld; v.en = e; v.dir = d; v.lv = lv;
        v.cnt = cnt; v.phase = phase; v.wrap = wrap; v.ill = ill;
        vecs.push_back(v);
    endfunction

    // The sequence is defined by phase: phase k <= w has k leading ones, and
    // phase k > w has 2w-k trailing ones.
    function automatic int unsigned state_of(int w, int k);
        if (k <= w) return ((32'd1 << k) - 1) << (w - k);
        return (32'd1 << (2 * w - k)) - 1;
    endfunction

    function automatic int phase_of(int w, int unsigned v);
        for (int k = 0; k < 2 * w; k++) begin
            if (state_of(w, k) == v) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input int w, input bit sc, inout int unsigned v,
                              output bit wr, output bit il,
                              input bit c, input bit ld, input bit e, input bit d,
                              input int unsigned lv);
        int          ph;
        int          nph;
        int unsigned mask;
        mask = (32'd1 << w) - 1;
        wr = 1'b0;
        il = 1'b0;
        if (c) begin
            v = 0;
        end else if (ld) begin
            if (phase_of(w, lv) < 0) begin
                il = 1'b1;
                v  = sc ? 0 : lv;
            end else begin
                v = lv;
            end
        end else if (e) begin
            ph = phase_of(w, v);
            if (ph < 0) begin
                il = 1'b1;
                if (sc)      v = 0;
                else if (d)  v = ((~v & 1) << (w - 1)) | (v >> 1);
                else         v = ((v << 1) & mask) | ((~(v >> (w - 1))) & 1);
            end else begin
                nph = d ? (ph + 1) % (2 * w) : (ph + 2 * w - 1) % (2 * w);
                wr  = d ? (ph == 2 * w - 1) : (ph == 0);
                v   = state_of(w, nph);
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_inst(string tag, int w, int unsigned mv, bit mw, bit mi,
                            int acnt, int aph, int awr, int ail);
        chk({tag, "_cnt"}, acnt, int'(mv));
        if (phase_of(w, mv) >= 0) chk({tag, "_phase"}, aph, phase_of(w, mv));
        chk({tag, "_wrap"}, awr, int'(mw));
        chk({tag, "_illegal"}, ail, int'(mi));
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step(4, 1'b1, mv4,  mw4,  mi4,  clr, load, en, dir_up, int'(load_val4));
        model_step(4, 1'b0, mv4n, mw4n, mi4n, clr, load, en, dir_up, int'(load_val4));
        model_step(5, 1'b1, mv5,  mw5,  mi5,  clr, load, en, dir_up, int'(load_val5));
        #1;
        chk_inst("d4",  4, mv4,  mw4,  mi4,  int'(cnt4),  int'(ph4),  int'(wr4),  int'(il4));
        chk_inst("d4n", 4, mv4n, mw4n, mi4n, int'(cnt4n), int'(ph4n), int'(wr4n), int'(il4n));
        chk_inst("d5",  5, mv5,  mw5,  mi5,  int'(cnt5),  int'(ph5),  int'(wr5),  int'(il5));
    endtask

    task automatic set_in(logic c, logic ld, logic e, logic d, logic [3:0] lv4, logic [4:0] lv5);
        clr = c; load = ld; en = e; dir_up = d; load_val4 = lv4; load_val5 = lv5;
    endtask

    task automatic model_reset();
        mv4 = 0; mv4n = 0; mv5 = 0;
        mw4 = 0; mw4n = 0; mw5 = 0; mi4 = 0; mi4n = 0; mi5 = 0;
    endtask

    initial begin
        int wraps;
        int distinct;
        bit seen[10];

        rst_n = 1'b0;
        set_in(0, 0, 0, 1, 4'd0, 5'd0);
        model_reset();

        // Forward run 1..7, 0 (wrap), 1.
        add_vec(0,0,1,1,4'b0000, 4'b1000,1,0,0);
        add_vec(0,0,1,1,4'b0000, 4'b1100,2,0,0);
        add_vec(0,0,1,1,4'b0000, 4'b1110,3,0,0);
        add_vec(0,0,1,1,4'b0000, 4'b1111,4,0,0);
        add_vec(0,0,1,1,4'b0000, 4'b0111,5,0,0);
        add_vec(0,0,1,1,4'b0000, 4'b0011,6,0,0);
        add_vec(0,0,1,1,4'b0000, 4'b0001,7,0,0);
        add_vec(0,0,1,1,4'b0000, 4'b0000,0,1,0);
        add_vec(0,0,1,1,4'b0000, 4'b1000,1,0,0);
        // Clear, then reverse wrap, reverse, forward with no wrap.
        add_vec(1,0,0,1,4'b0000, 4'b0000,0,0,0);
        add_vec(0,0,1,0,4'b0000, 4'b0001,7,1,0);
        add_vec(0,0,1,0,4'b0000, 4'b0011,6,0,0);
        add_vec(0,0,1,1,4'b0000, 4'b0001,7,0,0);
        // Load beats step; clear beats load and step.
        add_vec(0,1,1,1,4'b1110, 4'b1110,3,0,0);
        add_vec(1,1,1,1,4'b1110, 4'b0000,0,0,0);
        // Illegal load is corrected, then the pulse drops.
        add_vec(0,1,0,1,4'b1010, 4'b0000,0,0,1);
        add_vec(0,0,0,1,4'b0000, 4'b0000,0,0,0);
        // Phase 5 holds under en=0.
        add_vec(0,1,0,1,4'b0111, 4'b0111,5,0,0);
        for (int i = 0; i < 5; i++) add_vec(0,0,0,i[0],4'b0000, 4'b0111,5,0,0);

        #12;
        chk("rst_cnt4",   int'(cnt4),  0);
        chk("rst_phase4", int'(ph4),   0);
        chk("rst_wrap4",  int'(wr4),   0);
        chk("rst_ill4",   int'(il4),   0);
        chk("rst_cnt5",   int'(cnt5),  0);
        chk("rst_cnt4n",  int'(cnt4n), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].dir, vecs[i].lv, 5'd0);
            do_cycle();
            chk($sformatf("tbl%0d_cnt", i),   int'(cnt4), int'(vecs[i].cnt));
            chk($sformatf("tbl%0d_phase", i), int'(ph4),  vecs[i].phase);
            chk($sformatf("tbl%0d_wrap", i),  int'(wr4),  int'(vecs[i].wrap));
            chk($sformatf("tbl%0d_ill", i),   int'(il4),  int'(vecs[i].ill));
        end

        // Without correction, an illegal load sticks, flags, and then steps with a flag.
        set_in(1, 0, 0, 1, 4'd0, 5'd0);      do_cycle();
        set_in(0, 1, 0, 1, 4'b1010, 5'd0);   do_cycle();
        chk("nc_load_cnt", int'(cnt4n), 4'b1010);
        chk("nc_load_ill", int'(il4n),  1);
        chk("sc_load_cnt", int'(cnt4),  0);
        set_in(0, 0, 1, 1, 4'd0, 5'd0);      do_cycle();
        chk("nc_step_cnt", int'(cnt4n), 4'b1101);
        chk("nc_step_ill", int'(il4n),  1);
        set_in(0, 0, 0, 1, 4'd0, 5'd0);      do_cycle();
        chk("nc_hold_cnt", int'(cnt4n), 4'b1101);
        chk("nc_hold_ill", int'(il4n),  0);

        // WIDTH=5 forward: 10 distinct states, phases 1..9,0, one wrap.
        set_in(1, 0, 0, 1, 4'd0, 5'd0);      do_cycle();
        wraps = 0;
        for (int i = 0; i < 10; i++) seen[i] = 1'b0;
        set_in(0, 0, 1, 1, 4'd0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            do_cycle();
            chk($sformatf("w5_phase%0d", i), int'(ph5), (i + 1) % 10);
            if (wr5) wraps++;
            if (phase_of(5, int'(cnt5)) >= 0) seen[phase_of(5, int'(cnt5))] = 1'b1;
        end
        distinct = 0;
        for (int i = 0; i < 10; i++) if (seen[i]) distinct++;
        chk("w5_wraps", wraps, 1);
        chk("w5_distinct", distinct, 10);

        // Asynchronous reset between edges.
        set_in(0, 0, 1, 1, 4'd0, 5'd0);
        do_cycle(); do_cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt4",  int'(cnt4),  0);
        chk("arst_ph4",   int'(ph4),   0);
        chk("arst_cnt5",  int'(cnt5),  0);
        chk("arst_cnt4n", int'(cnt4n), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            clr       = ($urandom_range(0, 19) == 0);
            load      = ($urandom_range(0, 5) == 0);
            en        = ($urandom_range(0, 3) != 0);
            dir_up    = $urandom_range(0, 1) == 1;
            load_val4 = ($urandom_range(0, 1) == 1) ? 4'(state_of(4, $urandom_range(0, 7)))
                                                    : 4'($urandom);
            load_val5 = ($urandom_range(0, 1) == 1) ? 5'(state_of(5, $urandom_range(0, 9)))
                                                    : 5'($urandom);
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/johnson_cnt_ctrl.md
Name: johnson_cnt_ctrl

Overview:
Parametrised Johnson (twisted-ring) counter with enable, up/down direction, synchronous clear and load, and illegal-state detection and self-correction. It also provides a registered phase index and a wrap pulse. Used as a glitch-free 2*WIDTH-phase sequencer and clock-phase/strobe generator in the counter library.

Parameters:
WIDTH, 4, ring length in flops; legal range 2..32; the sequence has 2*WIDTH states
SELF_CORRECT, 1, 1 = illegal states and illegal load values are forced to all-zeros; 0 = no correction, the illegal flag is still reported
PW, $clog2(2*WIDTH), width of the phase index (derived; must not be overridden)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  step enable; one ring step per enabled cycle
dir_up  input  1  1 = forward step, 0 = reverse step
clr  input  1  synchronous clear to all-zeros
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value to load
o_cnt  output  WIDTH  ring state (registered)
o_phase  output  PW  phase index 0..2*WIDTH-1 of o_cnt (registered)
o_wrap  output  1  one-cycle pulse on a sequence wrap (registered)
o_illegal  output  1  one-cycle pulse when an illegal state or load is detected (registered)

Behaviour:
- Reset (rst_n low, asynchronous): o_cnt = 0, o_phase = 0, o_wrap = 0, o_illegal = 0. Release is synchronous to clk by the system.
- Priority per cycle: clr > load > en > hold. All actions take effect at the next rising edge; latency is 1 cycle.
- Forward step: cnt <= {~cnt[0], cnt[WIDTH-1:1]}. For WIDTH=4 the sequence is 0000,1000,1100,1110,1111,0111,0011,0001,0000.
- Reverse step: cnt <= {cnt[WIDTH-2:0], ~cnt[WIDTH-1]}. This is the exact inverse of the forward step.
- Legal states: MSB-aligned ones then zeros (1..10..0, including all-zeros), or zeros then ones (0..01..1, including all-ones).
- Phase index, with p = popcount(cnt): phase = p if cnt[WIDTH-1] = 1 or cnt = 0; otherwise phase = 2*WIDTH - p. o_phase is computed from the next state and registered alongside o_cnt, so it is always consistent with o_cnt.
- o_wrap = 1 for the cycle in which o_cnt shows the result of either:
  - a forward step from phase 2*WIDTH-1 to phase 0, or
  - a reverse step from phase 0 to phase 2*WIDTH-1.
  clr, load and hold never raise o_wrap.
- Illegal current state while en = 1 (and no clr or load):
  - SELF_CORRECT = 1: next state is all-zeros and o_illegal pulses.
  - SELF_CORRECT = 0: the step proceeds as normal and o_illegal pulses.
  - With en = 0, an illegal state holds and no flag is raised.
- Load of an illegal load_val:
  - SELF_CORRECT = 1: state becomes all-zeros and o_illegal pulses.
  - SELF_CORRECT = 0: the value is loaded and o_illegal pulses.
- Phase of an illegal state under SELF_CORRECT = 0 is don't-care but must be deterministic. Because the counter starts legal after reset, illegal states arise only via load.
- clr asserted with load and/or en: clr wins; state = 0, o_wrap = 0, o_illegal = 0.
- Direction may change on any cycle. The next step uses the dir_up value sampled at that edge.
- rst_n asserted mid-sequence: all outputs go to reset values immediately, with no wait for clk.
- o_wrap and o_illegal are low on every cycle without a qualifying event; they never stretch beyond one cycle per event.

Test Plan:
- Reset then en=1, dir_up=1, WIDTH=4 for 9 cycles -> o_cnt 1000,1100,1110,1111,0111,0011,0001,0000,1000; o_phase 1..7,0,1; o_wrap high only on the 0000 cycle.
- From reset, en=1, dir_up=0 for 2 cycles -> o_cnt 0001 (phase 7, o_wrap=1), then 0011 (phase 6, o_wrap=0). Toggle dir_up=1 for 1 cycle -> back to 0001 with no wrap.
- Load 4'b1110 with en=1 in the same cycle -> o_cnt=1110, o_phase=3, no step. Next cycle with clr=1, load=1, en=1 -> o_cnt=0000, o_phase=0, o_wrap=0.
- SELF_CORRECT=1: load 4'b1010 -> o_cnt=0000, o_illegal=1 for one cycle. SELF_CORRECT=0: same load -> o_cnt=1010, o_illegal=1. Then en=1 -> o_illegal=1 again and o_cnt=1101.
- en=0 for 5 cycles at phase 5 -> o_cnt holds 0111, o_wrap=0, o_illegal=0.
- WIDTH=5, forward, 10 steps -> all 10 legal states visited once, o_phase 1..9,0, one o_wrap. Assert rst_n low mid-step between edges -> o_cnt=0 asynchronously.
